cdc_afifo_rd_stream: RTL and testbench
======================================

Name: cdc_afifo_rd_stream

Overview:
- Single-clock read-end adapter for the async FIFO. It drains the FIFO's read port (rd strobe, rdata, rempty) and presents the words as a registered valid/ready stream.
- A 2-entry skid buffer gives full throughput under downstream backpressure. A beat counter frames the stream into fixed-length packets (o_last).
- Sits in the read clock domain, directly after the FIFO, in front of consumers that need a standard valid/ready interface.

Parameters:
- dbits, 32, payload width; must equal the FIFO dbits.
- pkt_len, 8, beats per packet, >= 1; o_last is marked on beat pkt_len-1.
- cbits, 3, beat counter width; cbits = max(1, clog2(pkt_len)).

Ports:
- i_clk  in  1  clock; the same clock as the FIFO read clock.
- i_nrst  in  1  reset, synchronous, active-low.
- o_fifo_rd  out  1  pop strobe to the FIFO read port.
- i_fifo_rdata  in  dbits  FIFO head word; valid whenever i_fifo_rempty=0.
- i_fifo_rempty  in  1  FIFO empty flag, registered in the read domain.
- o_valid  out  1  stream word valid.
- o_data  out  dbits  stream payload.
- o_last  out  1  last beat of a packet.
- i_ready  in  1  downstream accepts the word.
- i_flush  in  1  discard the buffer and drain the FIFO.
- o_level  out  2  skid buffer occupancy, 0..2.
- o_beat  out  cbits  index of the current beat within the packet.

Behaviour:
- Reset: i_nrst is sampled only at the i_clk edge; there is no async path. While i_nrst=0, o_fifo_rd=0 (combinationally gated), so no FIFO word is consumed during reset. Reset clears cnt, head, tail and beat to 0. After reset: o_valid=0, o_last=0, o_level=0, o_beat=0, o_data=0.
- State: buf[0..1] (dbits each), head (1b), tail (1b), cnt (2b), beat (cbits).
- Pop rule: pop = i_nrst & ~i_fifo_rempty & (cnt<2 | i_flush).
  - o_fifo_rd = pop.
  - On pop without flush, buf[tail] <= i_fifo_rdata and tail toggles.
- Accept rule: acc = o_valid & i_ready.
  - On acc, head toggles.
  - beat <= (beat==pkt_len-1) ? 0 : beat+1.
- Count update: cnt_next = cnt + pop - acc, evaluated without flush. cnt never exceeds 2 and never goes below 0.
- Outputs:
  - o_valid = (cnt!=0) & ~i_flush.
  - o_data = buf[head], driven only from registers.
  - o_last = o_valid & (beat==pkt_len-1).
  - o_level = cnt; o_beat = beat.
- Latency: a word at the FIFO head with rempty=0 in cycle N is popped at edge N and appears on o_data/o_valid in cycle N+1.
- Throughput: with cnt=1, a pop and an acc can occur in the same cycle, giving one word per cycle sustained.
- cnt==2 with acc: no pop that cycle; cnt goes to 1, and popping resumes on the next cycle.
- Backpressure: o_data stays stable while o_valid=1 and i_ready=0. A word is never dropped or duplicated.
- pkt_len=1: o_last = o_valid on every beat; beat stays 0.
- i_flush=1 (synchronous, level):
  - Next state: cnt=0, head=tail=0, beat=0.
  - o_valid is forced to 0 in the same cycle.
  - o_fifo_rd = ~i_fifo_rempty, so popped words are discarded.
  - Normal operation resumes the cycle after i_flush falls.
- Reset mid-packet: beat returns to 0. Buffered words are lost. The FIFO itself is reset by the same i_nrst.
- Arithmetic: all counters are unsigned; head and tail wrap modulo 2; beat wraps modulo pkt_len.

Decomposition:
- Package cdc_afifo_pkg holds:
  - the register struct type cdc_afifo_rd_stream_registers (buf, head, tail, cnt, beat);
  - its reset constant;
  - the level width constant (2).
- No sub-module; the skid buffer is inline.
- An integration wrapper instantiates cdc_afifo plus this block; that wrapper is not part of this block.

Test Plan:
1. Reset: hold i_nrst=0 for 3 clocks with FIFO non-empty -> o_fifo_rd=0 throughout; o_valid=0, o_level=0, o_beat=0 after release.
2. Streaming: write 16 words 0x100..0x10F into the FIFO; i_ready=1 constant -> first o_valid one cycle after rempty falls; 16 consecutive beats in order; o_last on 0x107 and 0x10F.
3. Backpressure:
   - Setup: 8 words queued; i_ready toggles 1,0,0,1 repeating.
   - Required: o_level never exceeds 2; o_data holds while stalled; order 0..7 preserved; no pop in any cycle where o_level=2 and no acc.
4. Flush:
   - Setup: o_beat=3, o_level=2, 5 words in the FIFO; pulse i_flush for 6 cycles.
   - Required: o_valid=0 during the flush; the FIFO drains to rempty=1; afterwards o_level=0 and o_beat=0; the next word written is delivered with o_beat=0.
5. pkt_len=1 build: send 4 words -> o_last=1 on all 4; o_beat stays 0.
6. Random: randomized FIFO writes, i_ready and i_flush over 10k cycles -> scoreboard matches all unflushed words in order, and o_last falls every pkt_len accepted beats.

Source files
------------

// File: rtl/cdc_afifo_pkg.sv
// cdc_afifo_pkg: shared types and constants for the async FIFO read-side stream adapter
package cdc_afifo_pkg;
  localparam int unsigned fifo_dbits = 32;
  localparam int unsigned level_bits = 2;
  // Beat register is kept wide enough for any pkt_len up to 256; o_beat exposes the low cbits.
  localparam int unsigned beat_bits = 8;
  typedef struct packed {
    logic [1:0][fifo_dbits-1:0] data;
    logic                       head;
    logic                       tail;
    logic [level_bits-1:0]      cnt;
    logic [beat_bits-1:0]       beat;
  } cdc_afifo_rd_stream_registers;
  localparam cdc_afifo_rd_stream_registers rd_stream_reset = '0;
endpackage

// File: rtl/cdc_afifo_rd_stream.sv
// cdc_afifo_rd_stream: drains the async FIFO read port into a registered valid/ready packet stream
// i_clk/i_nrst: read-domain clock, synchronous active-low reset
// o_fifo_rd, i_fifo_rdata, i_fifo_rempty: FIFO read port (pop strobe, head word, empty flag)
// o_valid, o_data, o_last, i_ready: output stream, o_last marks beat pkt_len-1
// i_flush: discard buffered words and drain the FIFO while high
// o_level, o_beat: skid buffer occupancy and beat index within the packet
module cdc_afifo_rd_stream
  import cdc_afifo_pkg::*;
#(
  parameter int dbits   = fifo_dbits,
  parameter int pkt_len = 8,
  parameter int cbits   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  output logic                  o_fifo_rd,
  input  logic [dbits-1:0]      i_fifo_rdata,
  input  logic                  i_fifo_rempty,
  output logic                  o_valid,
  output logic [dbits-1:0]      o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic [level_bits-1:0] o_level,
  output logic [cbits-1:0]      o_beat
);
  localparam logic [beat_bits-1:0] last_beat = beat_bits'(pkt_len - 1);
  cdc_afifo_rd_stream_registers r, n;
  logic pop, acc;
  always_comb begin
    // Pop is gated by reset so nothing is consumed while the FIFO is also held in reset;
    // during flush the FIFO is drained regardless of occupancy and the words are discarded.
    pop = i_nrst & ~i_fifo_rempty & ((r.cnt < 2'd2) | i_flush);
    o_fifo_rd = pop;
    o_valid = (r.cnt != '0) & ~i_flush;
    acc = o_valid & i_ready;
    o_data = r.data[r.head];
    o_last = o_valid & (r.beat == last_beat);
    o_level = r.cnt;
    o_beat = r.beat[cbits-1:0];
    n = r;
    if (i_flush) begin
      n.cnt = '0;
      n.head = 1'b0;
      n.tail = 1'b0;
      n.beat = '0;
    end else begin
      if (pop) begin
        n.data[r.tail] = i_fifo_rdata;
        n.tail = ~r.tail;
      end
      if (acc) begin
        n.head = ~r.head;
        n.beat = (r.beat == last_beat) ? '0 : r.beat + 1'b1;
      end
      n.cnt = r.cnt + {1'b0, pop} - {1'b0, acc};
    end
  end
  always_ff @(posedge i_clk) r <= i_nrst ? n : rd_stream_reset;
endmodule

// File: tb/tb_cdc_afifo_rd_stream.sv
// tb_cdc_afifo_rd_stream: scoreboard bench for the FIFO read-side stream adapter
module tb_cdc_afifo_rd_stream;
  localparam int PKT = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst = 1'b0;
  logic o_fifo_rd, o_valid, o_last;
  logic [31:0] i_fifo_rdata = '0, o_data;
  logic i_fifo_rempty = 1'b1, i_ready = 1'b0, i_flush = 1'b0;
  logic [1:0] o_level;
  logic [2:0] o_beat;
  logic rd1, valid1, last1, beat1, rempty1 = 1'b1, ready1 = 1'b0;
  logic [31:0] rdata1 = '0, data1;
  logic [1:0] level1;
  cdc_afifo_rd_stream #(.dbits(32), .pkt_len(PKT), .cbits(3)) dut (
    .i_clk(clk), .i_nrst(nrst), .o_fifo_rd(o_fifo_rd), .i_fifo_rdata(i_fifo_rdata),
    .i_fifo_rempty(i_fifo_rempty), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .i_ready(i_ready), .i_flush(i_flush), .o_level(o_level), .o_beat(o_beat));
  cdc_afifo_rd_stream #(.dbits(32), .pkt_len(1), .cbits(1)) dut1 (
    .i_clk(clk), .i_nrst(nrst), .o_fifo_rd(rd1), .i_fifo_rdata(rdata1),
    .i_fifo_rempty(rempty1), .o_valid(valid1), .o_data(data1), .o_last(last1),
    .i_ready(ready1), .i_flush(1'b0), .o_level(level1), .o_beat(beat1));
  int checks = 0, errors = 0, mbeat = 0, acc_total = 0;
  logic [31:0] fifo[$], sb[$];
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Called at posedge+1; drives one cycle, checks at negedge, updates the FIFO model after the edge.
  task automatic cycle(input bit wr, input logic [31:0] wd, input bit rdy, input bit fl);
    logic [31:0] w;
    i_ready = rdy;
    i_flush = fl;
    @(negedge clk);
    chk("level", 32'(o_level), 32'(sb.size()));
    chk("valid", 32'(o_valid), 32'((sb.size() != 0) && !fl));
    chk("rd", 32'(o_fifo_rd), 32'(!i_fifo_rempty && (sb.size() < 2 || fl)));
    chk("beat", 32'(o_beat), 32'(mbeat));
    chk("last", 32'(o_last), 32'(o_valid && mbeat == PKT - 1));
    if (prev_stall && !fl) chk("hold", o_data, prev_data);
    if (o_valid && rdy) begin
      if (sb.size() == 0) chk("spurious", 32'd1, 32'd0);
      else begin
        w = sb.pop_front();
        chk("data", o_data, w);
      end
      mbeat = (mbeat == PKT - 1) ? 0 : mbeat + 1;
      acc_total++;
    end
    prev_stall = o_valid && !rdy && !fl;
    prev_data = o_data;
    if (o_fifo_rd && fifo.size() != 0) begin
      w = fifo.pop_front();
      if (!fl) sb.push_back(w);
    end
    if (fl) begin
      sb.delete();
      mbeat = 0;
    end
    @(posedge clk);
    #1;
    if (wr) fifo.push_back(wd);
    i_fifo_rempty = (fifo.size() == 0);
    i_fifo_rdata = (fifo.size() != 0) ? fifo[0] : '0;
  endtask
  initial begin
    int start, fl_left;
    bit wr, rdy, fl;
    // Reset with a non-empty FIFO: nothing may be popped.
    fifo.push_back(32'hdead);
    i_fifo_rempty = 1'b0;
    i_fifo_rdata = 32'hdead;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd", 32'(o_fifo_rd), 32'd0);
    end
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_data", o_data, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    fifo.delete();
    i_fifo_rempty = 1'b1;
    i_fifo_rdata = '0;
    @(negedge clk);
    chk("rel_valid", 32'(o_valid), 32'd0);
    chk("rel_level", 32'(o_level), 32'd0);
    chk("rel_beat", 32'(o_beat), 32'd0);
    chk("rel_last", 32'(o_last), 32'd0);
    @(posedge clk);
    #1;
    // Streaming with constant ready.
    start = acc_total;
    cycle(1, 32'h100, 1, 0);
    chk("lat_pre", 32'(o_valid), 32'd0);
    cycle(1, 32'h101, 1, 0);
    chk("lat_first", 32'(o_valid), 32'd1);
    chk("lat_data", o_data, 32'h100);
    for (int i = 2; i < 16; i++) cycle(1, 32'h100 + 32'(i), 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    chk("stream_cnt", 32'(acc_total - start), 32'd16);
    // Backpressure with ready pattern 1,0,0,1.
    start = acc_total;
    for (int i = 0; i < 60; i++) cycle(i < 8, 32'(i), (i % 4 == 0) || (i % 4 == 3), 0);
    chk("bp_cnt", 32'(acc_total - start), 32'd8);
    chk("bp_sb", 32'(sb.size()), 32'd0);
    // Flush: build beat=3, level=2, five words left in the FIFO.
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + 32'(i), 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(1, 32'h210 + 32'(i), 0, 0);
    chk("fl_lvl", 32'(o_level), 32'd2);
    chk("fl_beat", 32'(o_beat), 32'd3);
    chk("fl_fifo", 32'(fifo.size()), 32'd5);
    repeat (6) cycle(0, 0, 1, 1);
    chk("fl_empty", 32'(i_fifo_rempty), 32'd1);
    chk("fl_lvl0", 32'(o_level), 32'd0);
    chk("fl_beat0", 32'(o_beat), 32'd0);
    cycle(1, 32'h300, 1, 0);
    cycle(0, 0, 1, 0);
    chk("post_valid", 32'(o_valid), 32'd1);
    chk("post_data", o_data, 32'h300);
    chk("post_beat", 32'(o_beat), 32'd0);
    cycle(0, 0, 1, 0);
    // pkt_len=1 instance: every beat is last, beat stays 0.
    ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdata1 = 32'h400 + 32'(i);
      rempty1 = 1'b0;
      @(negedge clk);
      chk("p1_rd", 32'(rd1), 32'd1);
      if (i > 0) begin
        chk("p1_valid", 32'(valid1), 32'd1);
        chk("p1_last", 32'(last1), 32'd1);
        chk("p1_beat", 32'(beat1), 32'd0);
        chk("p1_data", data1, 32'h400 + 32'(i - 1));
      end
      @(posedge clk);
      #1;
    end
    rempty1 = 1'b1;
    @(negedge clk);
    chk("p1_valid", 32'(valid1), 32'd1);
    chk("p1_last", 32'(last1), 32'd1);
    chk("p1_beat", 32'(beat1), 32'd0);
    chk("p1_data", data1, 32'h403);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("p1_idle", 32'({valid1, last1}), 32'd0);
    @(posedge clk);
    #1;
    // Random writes, ready and flush.
    fl_left = 0;
    for (int i = 0; i < 10000; i++) begin
      wr = (fifo.size() < 16) && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      if (fl_left > 0) fl_left--;
      else if ($urandom_range(0, 63) == 0) fl_left = $urandom_range(1, 3);
      fl = (fl_left > 0);
      cycle(wr, $urandom, rdy, fl);
    end
    repeat (40) cycle(0, 0, 1, 0);
    chk("rand_sb", 32'(sb.size()), 32'd0);
    chk("rand_fifo", 32'(fifo.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
